// File: rtl/ram_read_demux.sv
// ram_read_demux
//   Reads a block of bytes from the shared RAM and hands each byte to one
//   downstream consumer. The consumer is chosen by the mode latched on Start:
//     {Load,Image,Layer} = 100 -> compressor
//                          110 -> output file writer
//                          001 -> CNN layer input
//   Any other mode ends the transfer at once with Done and Error.
//   Each byte uses three states: ISSUE (read strobe), CAPTURE (register the
//   RAM data) and PRESENT (Valid held until Ready).
//
// Ports
//   clk, rst                        clock, async active-high reset
//   Start, Load, Image, Layer       transfer request and mode, sampled in IDLE
//   BaseAddr, Length                first address and byte count, sampled in IDLE
//   RAMRead, RAMAddr, FromRAM       RAM read port (data returns one cycle later)
//   DataOut                         registered byte, shared by all consumers
//   ValidCompress/ReadyCompress     compressor handshake
//   ValidFile/ReadyFile             file writer handshake
//   ValidLayer/ReadyLayer           layer input handshake
//   Busy, Done, Error               status; Done/Error are one-cycle pulses
module ram_read_demux #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Load,
  input  logic              Image,
  input  logic              Layer,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [LEN_W-1:0]  Length,
  output logic              RAMRead,
  output logic [ADDR_W-1:0] RAMAddr,
  input  logic [7:0]        FromRAM,
  output logic [7:0]        DataOut,
  output logic              ValidCompress,
  input  logic              ReadyCompress,
  output logic              ValidFile,
  input  logic              ReadyFile,
  output logic              ValidLayer,
  input  logic              ReadyLayer,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [2:0] M_COMP  = 3'b100;
  localparam logic [2:0] M_FILE  = 3'b110;
  localparam logic [2:0] M_LAYER = 3'b001;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, PRESENT, FINISH} state_t;

  state_t              state;
  logic [2:0]          mode;
  logic [ADDR_W-1:0]   base;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    idx;
  logic [LEN_W-1:0]    idx_nxt;
  logic [2:0]          req_mode;
  logic                handshake;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == M_COMP) || (m == M_FILE) || (m == M_LAYER);
  endfunction

  assign req_mode = {Load, Image, Layer};
  assign idx_nxt  = idx + 1'b1;

  // Only the selected Valid is ever high, so Ready of the other consumers
  // cannot contribute to a handshake.
  assign handshake = (ValidCompress & ReadyCompress) |
                     (ValidFile     & ReadyFile)     |
                     (ValidLayer    & ReadyLayer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode          <= '0;
      base          <= '0;
      len           <= '0;
      idx           <= '0;
      RAMRead       <= 1'b0;
      RAMAddr       <= '0;
      DataOut       <= '0;
      ValidCompress <= 1'b0;
      ValidFile     <= 1'b0;
      ValidLayer    <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Error         <= 1'b0;
    end else begin
      // Strobes default low; each state raises them only for one cycle.
      RAMRead <= 1'b0;
      Done    <= 1'b0;
      Error   <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            mode <= req_mode;
            base <= BaseAddr;
            len  <= Length;
            idx  <= '0;
            Busy <= 1'b1;
            if (!mode_legal(req_mode)) begin
              state <= FINISH;
              Done  <= 1'b1;
              Error <= 1'b1;
            end else if (Length == '0) begin
              state <= FINISH;
              Done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              RAMRead <= 1'b1;
              RAMAddr <= BaseAddr;
            end
          end
        end
        ISSUE: begin
          // RAMRead/RAMAddr were registered on entry; data arrives next cycle.
          state <= CAPTURE;
        end
        CAPTURE: begin
          DataOut       <= FromRAM;
          ValidCompress <= (mode == M_COMP);
          ValidFile     <= (mode == M_FILE);
          ValidLayer    <= (mode == M_LAYER);
          state         <= PRESENT;
        end
        PRESENT: begin
          if (handshake) begin
            ValidCompress <= 1'b0;
            ValidFile     <= 1'b0;
            ValidLayer    <= 1'b0;
            idx           <= idx_nxt;
            if (idx_nxt == len) begin
              state <= FINISH;
              Done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              RAMRead <= 1'b1;
              // Sum is truncated to ADDR_W, giving the modulo wrap.
              RAMAddr <= base + ADDR_W'(idx_nxt);
            end
          end
        end
        FINISH: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
